// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline-stage register:
// occupancy encoding and default bundle widths.
package pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  localparam int DATA_W_DEF = 128;
  localparam int CTRL_W_DEF = 12;

  typedef enum logic [1:0] {
    OCC_EMPTY = ST_EMPTY,
    OCC_ONE   = ST_ONE,
    OCC_FULL  = ST_FULL
  } occ_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register: main entry plus one-entry skid buffer,
// registered in_ready, synchronous flush and a stall-cycle counter.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF,
  parameter int STAT_W = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        occupancy,
  output logic [STAT_W-1:0] stall_cnt
);

  occ_e              r_state;
  occ_e              w_state_nxt;
  logic [CTRL_W-1:0] r_main_ctrl;
  logic [DATA_W-1:0] r_main_data;
  logic [CTRL_W-1:0] r_skid_ctrl;
  logic [DATA_W-1:0] r_skid_data;

  logic w_main_valid;
  logic w_skid_valid;
  logic w_in_fire;
  logic w_out_fire;
  logic w_ld_main_in;
  logic w_ld_skid_in;
  logic w_ld_main_skid;

  // Valid bits are implied by occupancy, so they can never disagree with it.
  assign w_main_valid = (r_state != OCC_EMPTY);
  assign w_skid_valid = (r_state == OCC_FULL);
  assign in_ready     = ~w_skid_valid;
  assign w_in_fire    = in_valid & in_ready;
  assign w_out_fire   = w_main_valid & out_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) r_state <= OCC_EMPTY;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path infers a latch.
    w_state_nxt    = r_state;
    w_ld_main_in   = 1'b0;
    w_ld_skid_in   = 1'b0;
    w_ld_main_skid = 1'b0;
    unique case (r_state)
      OCC_EMPTY: begin
        if (w_in_fire) begin
          w_ld_main_in = 1'b1;
          w_state_nxt  = OCC_ONE;
        end
      end
      OCC_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_ld_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_ld_skid_in = 1'b1;
          w_state_nxt  = OCC_FULL;
        end else if (w_out_fire) begin
          w_state_nxt  = OCC_EMPTY;
        end
      end
      OCC_FULL: begin
        if (w_out_fire) begin
          w_ld_main_skid = 1'b1;
          w_state_nxt    = OCC_ONE;
        end
      end
      default: w_state_nxt = OCC_EMPTY;
    endcase
    // Flush kills everything held and anything accepted this cycle.
    if (flush) begin
      w_state_nxt    = OCC_EMPTY;
      w_ld_main_in   = 1'b0;
      w_ld_skid_in   = 1'b0;
      w_ld_main_skid = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the wide bundles are reset too so out_data is never X after reset.
      r_main_ctrl <= '0;
      r_main_data <= '0;
      r_skid_ctrl <= '0;
      r_skid_data <= '0;
    end else if (flush) begin
      r_main_ctrl <= '0;
      r_skid_ctrl <= '0;
    end else begin
      if (w_ld_main_in) begin
        r_main_ctrl <= in_ctrl;
        r_main_data <= in_data;
      end else if (w_ld_main_skid) begin
        r_main_ctrl <= r_skid_ctrl;
        r_main_data <= r_skid_data;
      end
      if (w_ld_skid_in) begin
        r_skid_ctrl <= in_ctrl;
        r_skid_data <= in_data;
      end
    end
  end

  assign out_valid = w_main_valid;
  assign out_ctrl  = w_main_valid ? r_main_ctrl : '0;
  assign out_data  = r_main_data;
  assign occupancy = r_state;

  sat_counter #(
    .W (STAT_W)
  ) u_stall_cnt (
    .clock   (clock),
    .reset_n (reset_n),
    .inc     (w_main_valid & ~out_ready),
    .clr     (stat_clr),
    .count   (stall_cnt)
  );

endmodule
